// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS-I instruction words from symbolic fields
// (operation select, rs, rt, rd, imm) and queues them in a small FIFO with
// valid/ready handshakes on both sides, feeding the monocycle core's
// instruction stream or the instruction-memory load path.
//
// Optional feature macro: INSTR_ENC_JUMP_EN
//   defined     -> in_sel = 8 encodes J {6'h02, in_imm[25:0]}
//   not defined -> in_sel = 8 is treated as illegal, like 9..15
//
// Illegal selects still complete their handshake but write nothing; they set
// the sticky err_illegal flag, which only reset clears.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_sel,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [25:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW:0]   count,
    output logic          err_illegal
);

    // Operation select codes presented on in_sel
    localparam logic [3:0] SEL_ADD = 4'd0;
    localparam logic [3:0] SEL_SUB = 4'd1;
    localparam logic [3:0] SEL_AND = 4'd2;
    localparam logic [3:0] SEL_OR  = 4'd3;
    localparam logic [3:0] SEL_SLT = 4'd4;
    localparam logic [3:0] SEL_LW  = 4'd5;
    localparam logic [3:0] SEL_SW  = 4'd6;
    localparam logic [3:0] SEL_BEQ = 4'd7;
`ifdef INSTR_ENC_JUMP_EN
    localparam logic [3:0] SEL_J   = 4'd8;
`endif

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef INSTR_ENC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
`endif

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          accept;
    logic          push;
    logic          pop;

`ifndef INSTR_ENC_JUMP_EN
    // Upper immediate bits only matter for J; keep them visibly consumed.
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[25:16];
`endif

    // Full blocks writes outright, even if a pop happens in the same cycle.
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? mem[rd_ptr] : 32'h0000_0000;

    assign accept = in_valid && in_ready;
    assign push   = accept && enc_legal;
    assign pop    = out_valid && out_ready;

    // Encode the current field set; anything unrecognised is flagged illegal
    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        case (in_sel)
            SEL_ADD: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_ADD};
            SEL_SUB: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_SUB};
            SEL_AND: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_AND};
            SEL_OR:  enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_OR};
            SEL_SLT: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'h00, FN_SLT};
            SEL_LW:  enc_word = {OP_LW,  in_rs, in_rt, in_imm[15:0]};
            SEL_SW:  enc_word = {OP_SW,  in_rs, in_rt, in_imm[15:0]};
            SEL_BEQ: enc_word = {OP_BEQ, in_rs, in_rt, in_imm[15:0]};
`ifdef INSTR_ENC_JUMP_EN
            SEL_J:   enc_word = {OP_J, in_imm[25:0]};
`endif
            default: enc_legal = 1'b0;
        endcase
    end

    // Storage array is not reset; out_instr is masked to zero while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky illegal-select flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_illegal <= 1'b0;
        end else if (accept && !enc_legal) begin
            err_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder. Accepted legal words
// are queued as expected values; a monitor compares each word as it leaves.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_sel;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [25:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  count;
    logic        err_illegal;

    int          checks;
    int          failures;
    logic [31:0] sb[$];
    logic        held_valid;
    logic [31:0] held_word;

    instr_encoder #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .count(count), .err_illegal(err_illegal)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present one field set, wait (bounded) for in_ready, queue the expected word if legal
    task automatic applyStimulus(input logic [3:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [25:0] imm,
                                 input logic legal, input logic [31:0] expected);
        int waited;
        in_sel   = sel;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
        end else if (legal) begin
            sb.push_back(expected);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare each departing word, and check a stalled head stays put
    always @(negedge clk) begin
        if (rst || !out_valid) begin
            held_valid <= 1'b0;
        end else if (out_ready) begin
            held_valid <= 1'b0;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word: got %h, expected no word", out_instr);
            end else begin
                checkOutput("out_instr", out_instr, sb.pop_front());
            end
        end else begin
            if (held_valid) begin
                checkOutput("stall_hold", out_instr, held_word);
            end
            held_valid <= 1'b1;
            held_word  <= out_instr;
        end
    end

    initial begin
        int waited;
        checks     = 0;
        failures   = 0;
        held_valid = 1'b0;
        held_word  = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_imm    = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_err", 32'(err_illegal), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: ADD, visible one cycle after accept, then drained
        out_ready = 1'b1;
        applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'h00221820);
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_word", out_instr, 32'h00221820);
        @(posedge clk);
        #1;
        checkOutput("add_drained", 32'(count), 32'd0);

        // Remaining R-types
        applyStimulus(4'd1, 5'd4,  5'd5,  5'd6,  26'd0, 1'b1, 32'h00853022);
        applyStimulus(4'd2, 5'd7,  5'd8,  5'd9,  26'd0, 1'b1, 32'h00E84824);
        applyStimulus(4'd3, 5'd31, 5'd0,  5'd31, 26'd0, 1'b1, 32'h03E0F825);
        applyStimulus(4'd4, 5'd10, 5'd11, 5'd12, 26'd0, 1'b1, 32'h014B602A);

        // 2: LW / SW back-to-back; rd is ignored for I-type
        applyStimulus(4'd5, 5'd29, 5'd8, 5'd31, 26'd4, 1'b1, 32'h8FA80004);
        applyStimulus(4'd6, 5'd29, 5'd8, 5'd0,  26'd8, 1'b1, 32'hAFA80008);

        // 3: BEQ, upper immediate bits ignored, no sign extension
        applyStimulus(4'd7, 5'd1, 5'd2, 5'd0, 26'h3FFFFFF, 1'b1, 32'h1022FFFF);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("beq_drained", 32'(count), 32'd0);

        // 4: fill while stalled, full refuses a push even alongside a pop
        out_ready = 1'b0;
        applyStimulus(4'd1, 5'd4,  5'd5,  5'd6,  26'd0, 1'b1, 32'h00853022);
        applyStimulus(4'd2, 5'd7,  5'd8,  5'd9,  26'd0, 1'b1, 32'h00E84824);
        applyStimulus(4'd3, 5'd31, 5'd0,  5'd31, 26'd0, 1'b1, 32'h03E0F825);
        applyStimulus(4'd4, 5'd10, 5'd11, 5'd12, 26'd0, 1'b1, 32'h014B602A);
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        in_sel = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_imm = 26'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("full_held_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("full_pop_push_count", 32'(count), 32'd3);
        checkOutput("after_pop_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        sb.push_back(32'h00221820);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("fifth_accepted", 32'(count), 32'd4);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("fill_drained", 32'(count), 32'd0);

        // 5: illegal selects drop the word and latch err_illegal
        applyStimulus(4'd9, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0);
        checkOutput("ill9_count", 32'(count), 32'd0);
        checkOutput("ill9_err", 32'(err_illegal), 32'd1);
`ifdef INSTR_ENC_JUMP_EN
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd0, 26'h10, 1'b1, 32'h08000010);
        checkOutput("j_count", 32'(count), 32'd1);
`else
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd0, 26'h10, 1'b0, 32'h0);
        checkOutput("sel8_count", 32'(count), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_sticky", 32'(err_illegal), 32'd1);

        // 6: asynchronous reset mid-stream
        out_ready = 1'b0;
        applyStimulus(4'd5, 5'd29, 5'd8, 5'd0, 26'd4, 1'b1, 32'h8FA80004);
        applyStimulus(4'd6, 5'd29, 5'd8, 5'd0, 26'd8, 1'b1, 32'hAFA80008);
        applyStimulus(4'd0, 5'd1,  5'd2, 5'd3, 26'd0, 1'b1, 32'h00221820);
        checkOutput("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_count", 32'(count), 32'd0);
        checkOutput("async_rst_instr", out_instr, 32'h0);
        checkOutput("async_rst_err", 32'(err_illegal), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(4'd4, 5'd10, 5'd11, 5'd12, 26'd0, 1'b1, 32'h014B602A);
        checkOutput("resume_word", out_instr, 32'h014B602A);

        // Drain and confirm every expected word left the FIFO
        waited = 0;
        while (count != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("final_count", 32'(count), 32'd0);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
